// File: rtl/pc_uart_router_pkg.sv
// Shared types and constants for the PC UART router.
package pc_uart_router_pkg;

    // Router operating modes: local command parser, draining its response, bridge passthrough.
    typedef enum logic [1:0] {
        StCmd   = 2'd0,
        StDrain = 2'd1,
        StPass  = 2'd2
    } router_state_e;

    // "BLHE", first byte in the MSBs.
    localparam logic [31:0] DefaultEntrySeq = 32'h424C4845;

    // Number of clock cycles in the passthrough inactivity window.
    function automatic int unsigned idle_limit(input int unsigned clk_freq_hz,
                                               input int unsigned timeout_ms);
        return clk_freq_hz / 1000 * timeout_ms;
    endfunction

endpackage

// File: rtl/seq_matcher.sv
// Watches a byte stream for a fixed 4-byte sequence and pulses match on its last byte.
module seq_matcher
    import pc_uart_router_pkg::*;
#(
    parameter logic [31:0] SEQ = DefaultEntrySeq
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       strobe,
    input  logic       clear,
    output logic       match
);

    logic [1:0] idx_q, idx_d;
    logic [7:0] exp_byte;
    logic       hit;

    // Select the byte expected at the current position and flag the final hit.
    always_comb begin
        case (idx_q)
            2'd0:    exp_byte = SEQ[31:24];
            2'd1:    exp_byte = SEQ[23:16];
            2'd2:    exp_byte = SEQ[15:8];
            default: exp_byte = SEQ[7:0];
        endcase
        hit   = (data == exp_byte);
        match = strobe && hit && (idx_q == 2'd3);
    end

    // Advance on a hit (3 wraps to 0 on the full match); a miss may itself restart the sequence.
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = 2'd0;
        end else if (strobe) begin
            if (hit) begin
                idx_d = idx_q + 2'd1;
            end else begin
                idx_d = (data == SEQ[31:24]) ? 2'd1 : 2'd0;
            end
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/pc_uart_router.sv
// Shares one PC UART between the local command parser and the bridge, switching to
// passthrough on an entry sequence and back on inactivity or a software request.
module pc_uart_router
    import pc_uart_router_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 72_000_000,
    parameter int unsigned IDLE_TIMEOUT_MS = 5000,
    parameter logic [31:0] ENTRY_SEQ       = DefaultEntrySeq
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    output logic [7:0] cmd_rx_data,
    output logic       cmd_rx_valid,
    input  logic [7:0] cmd_tx_data,
    input  logic       cmd_tx_valid,
    output logic       cmd_tx_ready,
    output logic [7:0] br_rx_data,
    output logic       br_rx_valid,
    input  logic [7:0] br_tx_data,
    input  logic       br_tx_valid,
    output logic       br_tx_ready,
    input  logic       force_exit,
    output logic       bridge_enable,
    output logic       passthrough
);

    localparam int unsigned IdleLimit = idle_limit(CLK_FREQ_HZ, IDLE_TIMEOUT_MS);
    localparam int unsigned IdleW     = $clog2(IdleLimit) + 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleLimit - 1);

    router_state_e    state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [7:0]       rx_data_q;
    logic             cmd_rx_valid_q, br_rx_valid_q;
    logic             match, matcher_clear;
    logic             tx_stall, timeout, activity;

    // Bridge holding a byte the UART will not take yet; leaving now would strand it.
    assign tx_stall = br_tx_valid && !uart_tx_ready;
    // A byte arriving on the timeout cycle counts as activity and cancels the exit.
    assign timeout  = (idle_q >= IdleLast) && !uart_rx_valid;
    assign activity = uart_rx_valid || (br_tx_valid && uart_tx_ready);

    seq_matcher #(
        .SEQ (ENTRY_SEQ)
    ) u_seq_matcher (
        .clk    (clk),
        .rst    (rst),
        .data   (uart_rx_data),
        .strobe (uart_rx_valid && (state_q == StCmd)),
        .clear  (matcher_clear),
        .match  (match)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCmd;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the TX mux only changes once no transfer is half-done.
    always_comb begin
        state_d       = state_q;
        matcher_clear = 1'b0;
        case (state_q)
            StCmd: begin
                if (match) state_d = StDrain;
            end
            StDrain: begin
                if (!cmd_tx_valid) state_d = StPass;
            end
            StPass: begin
                if ((force_exit || timeout) && !tx_stall) begin
                    state_d       = StCmd;
                    matcher_clear = 1'b1;
                end
            end
            default: state_d = StCmd;
        endcase
    end

    // TX mux and status outputs, decoded from the current state.
    always_comb begin
        uart_tx_valid = cmd_tx_valid;
        uart_tx_data  = cmd_tx_data;
        cmd_tx_ready  = uart_tx_ready;
        br_tx_ready   = 1'b0;
        passthrough   = 1'b0;
        bridge_enable = 1'b0;
        if (state_q == StPass) begin
            uart_tx_valid = br_tx_valid;
            uart_tx_data  = br_tx_data;
            cmd_tx_ready  = 1'b0;
            br_tx_ready   = uart_tx_ready;
            passthrough   = 1'b1;
            bridge_enable = 1'b1;
        end
    end

    // Idle counter: zero outside PASS (so entry starts at 0), saturating to avoid wrap while stalled.
    always_comb begin
        if (state_q != StPass || state_d != StPass || activity) begin
            idle_d = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + IdleW'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    // RX steering: one register stage; bytes seen in DRAIN go nowhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rx_valid_q <= 1'b0;
            br_rx_valid_q  <= 1'b0;
            rx_data_q      <= 8'h00;
        end else begin
            cmd_rx_valid_q <= uart_rx_valid && (state_q == StCmd);
            br_rx_valid_q  <= uart_rx_valid && (state_q == StPass);
            if (uart_rx_valid) rx_data_q <= uart_rx_data;
        end
    end

    assign cmd_rx_valid = cmd_rx_valid_q;
    assign cmd_rx_data  = rx_data_q;
    assign br_rx_valid  = br_rx_valid_q;
    assign br_rx_data   = rx_data_q;

endmodule

// File: tb/tb_pc_uart_router.sv
// Self-checking bench for pc_uart_router: directed scenarios plus a randomized run
// against a byte-history / mode reference model.
module tb_pc_uart_router;

    // Clock scaled down so one idle window is 2,000 cycles; timeout arithmetic is unchanged.
    localparam int unsigned ClkFreqHz = 2_000_000;
    localparam int unsigned IdleMs    = 1;
    localparam int          Limit     = 2000;
    localparam int ModeCmd   = 0;
    localparam int ModeDrain = 1;
    localparam int ModePass  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_valid = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready = 1'b1;
    logic [7:0] cmd_rx_data;
    logic       cmd_rx_valid;
    logic [7:0] cmd_tx_data = 8'h00;
    logic       cmd_tx_valid = 1'b0;
    logic       cmd_tx_ready;
    logic [7:0] br_rx_data;
    logic       br_rx_valid;
    logic [7:0] br_tx_data = 8'h00;
    logic       br_tx_valid = 1'b0;
    logic       br_tx_ready;
    logic       force_exit = 1'b0;
    logic       bridge_enable;
    logic       passthrough;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int         m_mode = ModeCmd;
    int         m_idle = 0;
    logic [7:0] m_hist[$];
    bit         m_cmd_v = 1'b0;
    bit         m_br_v = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] seq_b[4];

    pc_uart_router #(
        .CLK_FREQ_HZ     (ClkFreqHz),
        .IDLE_TIMEOUT_MS (IdleMs),
        .ENTRY_SEQ       (32'h424C4845)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .cmd_rx_data   (cmd_rx_data),
        .cmd_rx_valid  (cmd_rx_valid),
        .cmd_tx_data   (cmd_tx_data),
        .cmd_tx_valid  (cmd_tx_valid),
        .cmd_tx_ready  (cmd_tx_ready),
        .br_rx_data    (br_rx_data),
        .br_rx_valid   (br_rx_valid),
        .br_tx_data    (br_tx_data),
        .br_tx_valid   (br_tx_valid),
        .br_tx_ready   (br_tx_ready),
        .force_exit    (force_exit),
        .bridge_enable (bridge_enable),
        .passthrough   (passthrough)
    );

    always #5 clk = ~clk;

    // Advance one clock: model the effect of the current inputs, then let the DUT take the edge.
    task automatic step();
        int         n_mode = m_mode;
        int         n_idle = m_idle;
        bit         n_cmd_v = 1'b0;
        bit         n_br_v = 1'b0;
        logic [7:0] n_data = m_data;
        bit         clr = 1'b0;
        if (rst) begin
            n_mode = ModeCmd;
            n_idle = 0;
            clr    = 1'b1;
        end else begin
            n_cmd_v = uart_rx_valid && (m_mode == ModeCmd);
            n_br_v  = uart_rx_valid && (m_mode == ModePass);
            if (uart_rx_valid) n_data = uart_rx_data;
            if (m_mode == ModeCmd) begin
                if (uart_rx_valid) begin
                    m_hist.push_back(uart_rx_data);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    if (m_hist.size() == 4 && m_hist[0] == seq_b[0] && m_hist[1] == seq_b[1]
                        && m_hist[2] == seq_b[2] && m_hist[3] == seq_b[3]) begin
                        n_mode = ModeDrain;
                        clr    = 1'b1;
                    end
                end
            end else if (m_mode == ModeDrain) begin
                if (!cmd_tx_valid) begin
                    n_mode = ModePass;
                    n_idle = 0;
                end
            end else begin
                if ((force_exit || (m_idle >= Limit - 1 && !uart_rx_valid))
                    && !(br_tx_valid && !uart_tx_ready)) begin
                    n_mode = ModeCmd;
                    n_idle = 0;
                    clr    = 1'b1;
                end else if (uart_rx_valid || (br_tx_valid && uart_tx_ready)) begin
                    n_idle = 0;
                end else begin
                    n_idle = m_idle + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_mode  = n_mode;
        m_idle  = n_idle;
        m_cmd_v = n_cmd_v;
        m_br_v  = n_br_v;
        m_data  = n_data;
        if (clr) m_hist.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        step();
        uart_rx_valid = 1'b0;
    endtask

    task automatic enter_pass();
        cmd_tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(seq_b[i]);
        vectors++;
        if (cmd_rx_valid !== 1'b1 || cmd_rx_data !== 8'h45) begin
            miscompares++;
            $display("FAIL entry_last_byte got v=%b d=%h want v=1 d=45", cmd_rx_valid, cmd_rx_data);
        end
        vectors++;
        if (passthrough !== 1'b0) begin
            miscompares++;
            $display("FAIL entry_drain got passthrough=%b want 0", passthrough);
        end
        step();
        vectors++;
        if (passthrough !== 1'b1 || bridge_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL entry_pass got pt=%b be=%b want 1 1", passthrough, bridge_enable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_tx_valid = 1'b1;
        cmd_tx_data  = 8'h5A;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h33;
        step();
        step();
        uart_rx_valid = 1'b0;
        vectors++;
        if (passthrough !== 1'b0 || bridge_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status got pt=%b be=%b want 0 0", passthrough, bridge_enable);
        end
        vectors++;
        if (cmd_rx_valid !== 1'b0 || br_rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rx got cmd=%b br=%b want 0 0", cmd_rx_valid, br_rx_valid);
        end
        vectors++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h5A || br_tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx got v=%b d=%h brr=%b want 1 5a 0",
                     uart_tx_valid, uart_tx_data, br_tx_ready);
        end
        rst = 1'b0;
        cmd_tx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        step();
    endtask

    task automatic test_cmd_bytes();
        logic [7:0] bytes[2];
        bytes[0] = 8'h01;
        bytes[1] = 8'h02;
        for (int i = 0; i < 2; i++) begin
            send_byte(bytes[i]);
            vectors++;
            if (cmd_rx_valid !== 1'b1 || cmd_rx_data !== bytes[i]) begin
                miscompares++;
                $display("FAIL cmd_byte%0d got v=%b d=%h want 1 %h", i, cmd_rx_valid, cmd_rx_data,
                         bytes[i]);
            end
            vectors++;
            if (br_rx_valid !== 1'b0 || passthrough !== 1'b0) begin
                miscompares++;
                $display("FAIL cmd_isolation%0d got br=%b pt=%b want 0 0", i, br_rx_valid,
                         passthrough);
            end
        end
        step();
        vectors++;
        if (cmd_rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_strobe_width got %b want 0", cmd_rx_valid);
        end
    endtask

    task automatic force_leave();
        force_exit = 1'b1;
        step();
        force_exit = 1'b0;
        vectors++;
        if (passthrough !== 1'b0 || bridge_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL force_exit got pt=%b be=%b want 0 0", passthrough, bridge_enable);
        end
    endtask

    task automatic test_entry();
        enter_pass();
        send_byte(8'h41);
        vectors++;
        if (br_rx_valid !== 1'b1 || br_rx_data !== 8'h41 || cmd_rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_rx got br=%b d=%h cmd=%b want 1 41 0", br_rx_valid, br_rx_data,
                     cmd_rx_valid);
        end
        force_leave();
    endtask

    task automatic test_overlap();
        logic [7:0] miss[5];
        send_byte(8'h42);
        enter_pass();
        force_leave();
        miss[0] = 8'h42; miss[1] = 8'h4C; miss[2] = 8'h00; miss[3] = 8'h48; miss[4] = 8'h45;
        for (int i = 0; i < 5; i++) send_byte(miss[i]);
        step();
        step();
        vectors++;
        if (passthrough !== 1'b0 || cmd_rx_data !== 8'h45) begin
            miscompares++;
            $display("FAIL broken_seq got pt=%b last=%h want 0 45", passthrough, cmd_rx_data);
        end
    endtask

    task automatic test_drain();
        cmd_tx_valid  = 1'b1;
        cmd_tx_data   = 8'h99;
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(seq_b[i]);
        vectors++;
        if (cmd_rx_valid !== 1'b1 || passthrough !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_fourth got cmd=%b pt=%b want 1 0", cmd_rx_valid, passthrough);
        end
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                uart_rx_valid = 1'b1;
                uart_rx_data  = 8'h77;
            end
            step();
            uart_rx_valid = 1'b0;
            vectors++;
            if (passthrough !== 1'b0 || uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h99
                || cmd_tx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_hold%0d got pt=%b v=%b d=%h rdy=%b want 0 1 99 0", i,
                         passthrough, uart_tx_valid, uart_tx_data, cmd_tx_ready);
            end
            vectors++;
            if (cmd_rx_valid !== 1'b0 || br_rx_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_discard%0d got cmd=%b br=%b want 0 0", i, cmd_rx_valid,
                         br_rx_valid);
            end
        end
        uart_tx_ready = 1'b1;
        #1;
        vectors++;
        if (cmd_tx_ready !== 1'b1 || uart_tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_accept got rdy=%b v=%b want 1 1", cmd_tx_ready, uart_tx_valid);
        end
        step();
        cmd_tx_valid = 1'b0;
        vectors++;
        if (passthrough !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_after_accept got pt=%b want 0", passthrough);
        end
        step();
        vectors++;
        if (passthrough !== 1'b1 || bridge_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_to_pass got pt=%b be=%b want 1 1", passthrough, bridge_enable);
        end
    endtask

    task automatic test_timeout();
        // Entered PASS on the previous edge: idle count is 0 now.
        repeat (Limit - 1) step();
        vectors++;
        if (passthrough !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early got pt=%b want 1", passthrough);
        end
        step();
        vectors++;
        if (passthrough !== 1'b0 || bridge_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_exit got pt=%b be=%b want 0 0", passthrough, bridge_enable);
        end
        enter_pass();
        repeat (Limit - 1) step();
        send_byte(8'h5C);
        vectors++;
        if (passthrough !== 1'b1 || br_rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_rescued got pt=%b br=%b want 1 1", passthrough, br_rx_valid);
        end
        repeat (Limit - 1) step();
        vectors++;
        if (passthrough !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_restart got pt=%b want 1", passthrough);
        end
        step();
        vectors++;
        if (passthrough !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_second_exit got pt=%b want 0", passthrough);
        end
    endtask

    task automatic test_force_stall();
        enter_pass();
        br_tx_valid   = 1'b1;
        br_tx_data    = 8'h42;
        uart_tx_ready = 1'b0;
        force_exit    = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (passthrough !== 1'b1 || uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h42
                || br_tx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d got pt=%b v=%b d=%h rdy=%b want 1 1 42 0", i,
                         passthrough, uart_tx_valid, uart_tx_data, br_tx_ready);
            end
            step();
        end
        uart_tx_ready = 1'b1;
        #1;
        vectors++;
        if (br_tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_accept got rdy=%b want 1", br_tx_ready);
        end
        step();
        br_tx_valid = 1'b0;
        force_exit  = 1'b0;
        vectors++;
        if (passthrough !== 1'b0 || bridge_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_exit got pt=%b be=%b want 0 0", passthrough, bridge_enable);
        end
        // Exit and a byte on the same cycle: byte still belongs to the bridge.
        enter_pass();
        force_exit = 1'b1;
        send_byte(8'h66);
        force_exit = 1'b0;
        vectors++;
        if (passthrough !== 1'b0 || br_rx_valid !== 1'b1 || br_rx_data !== 8'h66
            || cmd_rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL exit_last_byte got pt=%b br=%b d=%h cmd=%b want 0 1 66 0",
                     passthrough, br_rx_valid, br_rx_data, cmd_rx_valid);
        end
    endtask

    task automatic test_reset_mid_pass();
        enter_pass();
        br_tx_valid   = 1'b1;
        uart_tx_ready = 1'b0;
        cmd_tx_valid  = 1'b1;
        cmd_tx_data   = 8'h11;
        rst = 1'b1;
        send_byte(8'h23);
        vectors++;
        if (passthrough !== 1'b0 || bridge_enable !== 1'b0 || br_tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pass_status got pt=%b be=%b brr=%b want 0 0 0", passthrough,
                     bridge_enable, br_tx_ready);
        end
        vectors++;
        if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h11 || cmd_rx_valid !== 1'b0
            || br_rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pass_io got v=%b d=%h cmd=%b br=%b want 1 11 0 0", uart_tx_valid,
                     uart_tx_data, cmd_rx_valid, br_rx_valid);
        end
        rst = 1'b0;
        br_tx_valid = 1'b0;
        cmd_tx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        step();
    endtask

    task automatic test_random();
        int         burst = 0;
        logic [7:0] exp_tx_d;
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 499) == 0);
            uart_rx_valid = ($urandom_range(0, 2) == 0);
            if (uart_rx_valid) begin
                if (burst == 0 && $urandom_range(0, 11) == 0) burst = 4;
                if (burst > 0) begin
                    uart_rx_data = seq_b[4-burst];
                    burst--;
                end else begin
                    uart_rx_data = 8'($urandom_range(0, 255));
                end
            end
            cmd_tx_valid  = ($urandom_range(0, 1) == 0);
            cmd_tx_data   = 8'($urandom_range(0, 255));
            br_tx_valid   = ($urandom_range(0, 1) == 0);
            br_tx_data    = 8'($urandom_range(0, 255));
            uart_tx_ready = ($urandom_range(0, 2) != 0);
            force_exit    = ($urandom_range(0, 63) == 0);
            #2;
            exp_tx_d = (m_mode == ModePass) ? br_tx_data : cmd_tx_data;
            vectors++;
            if (passthrough !== (m_mode == ModePass) || bridge_enable !== (m_mode == ModePass)) begin
                miscompares++;
                $display("FAIL rand_mode c=%0d got pt=%b be=%b want mode=%0d", c, passthrough,
                         bridge_enable, m_mode);
            end
            vectors++;
            if (cmd_rx_valid !== m_cmd_v || br_rx_valid !== m_br_v
                || ((m_cmd_v || m_br_v) && cmd_rx_data !== m_data)) begin
                miscompares++;
                $display("FAIL rand_rx c=%0d got cmd=%b br=%b d=%h want %b %b %h", c,
                         cmd_rx_valid, br_rx_valid, cmd_rx_data, m_cmd_v, m_br_v, m_data);
            end
            vectors++;
            if (uart_tx_valid !== ((m_mode == ModePass) ? br_tx_valid : cmd_tx_valid)
                || uart_tx_data !== exp_tx_d
                || cmd_tx_ready !== ((m_mode != ModePass) && uart_tx_ready)
                || br_tx_ready !== ((m_mode == ModePass) && uart_tx_ready)) begin
                miscompares++;
                $display("FAIL rand_tx c=%0d got v=%b d=%h cr=%b br=%b mode=%0d", c,
                         uart_tx_valid, uart_tx_data, cmd_tx_ready, br_tx_ready, m_mode);
            end
            step();
        end
        rst = 1'b0;
        uart_rx_valid = 1'b0;
        cmd_tx_valid = 1'b0;
        br_tx_valid = 1'b0;
        force_exit = 1'b0;
        uart_tx_ready = 1'b1;
    endtask

    initial begin
        seq_b[0] = 8'h42;
        seq_b[1] = 8'h4C;
        seq_b[2] = 8'h48;
        seq_b[3] = 8'h45;
        #1;
        test_reset();
        test_cmd_bytes();
        test_entry();
        test_overlap();
        test_drain();
        test_timeout();
        test_force_stall();
        test_reset_mid_pass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_uart_router.md
PC_UART_ROUTER -- requirements
Module: pc_uart_router

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 72_000_000, meaning system clock frequency.
REQ-002 The block SHALL have parameter IDLE_TIMEOUT_MS, default 5000, meaning passthrough inactivity timeout.
REQ-003 The block SHALL have parameter ENTRY_SEQ, default 32'h424C4845 ("BLHE", MSB first), meaning the passthrough entry byte sequence.
REQ-004 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-005 Ports SHALL be as follows:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- uart_rx_data  in  8  byte from shared PC UART receiver
- uart_rx_valid  in  1  one-cycle strobe
- uart_tx_data  out  8  byte to shared PC UART transmitter
- uart_tx_valid  out  1
- uart_tx_ready  in  1
- cmd_rx_data  out  8  byte to local command parser
- cmd_rx_valid  out  1  one-cycle strobe
- cmd_tx_data  in  8  command parser response
- cmd_tx_valid  in  1
- cmd_tx_ready  out  1
- br_rx_data  out  8  to bridge pc_rx_data
- br_rx_valid  out  1  one-cycle strobe
- br_tx_data  in  8  from bridge pc_tx_data
- br_tx_valid  in  1
- br_tx_ready  out  1
- force_exit  in  1  software request to leave passthrough
- bridge_enable  out  1  drives bridge enable
- passthrough  out  1  status, high in state PASS

Function
REQ-006 States SHALL be CMD, DRAIN, and PASS; reset state is CMD.
REQ-007 In CMD, each uart_rx_valid SHALL produce cmd_rx_valid with identical data, registered with 1-cycle latency; br_rx_valid SHALL stay 0.
REQ-008 In CMD, the TX path SHALL connect cmd_tx_* to uart_tx_*: uart_tx_valid=cmd_tx_valid, uart_tx_data=cmd_tx_data, cmd_tx_ready=uart_tx_ready; br_tx_ready SHALL be 0.
REQ-009 In CMD, a 2-bit matcher SHALL compare incoming bytes against ENTRY_SEQ[31:24], [23:16], [15:8], [7:0] in order.
REQ-010 On a mismatching byte, the matcher index SHALL go to 1 if the byte equals ENTRY_SEQ[31:24], else to 0.
REQ-011 On the fourth consecutive match, the block SHALL go to DRAIN; the fourth byte is still forwarded to cmd.
REQ-012 In DRAIN, cmd_tx_ready SHALL follow uart_tx_ready, and incoming uart_rx bytes SHALL be discarded.
REQ-013 The block SHALL leave DRAIN for PASS on the first cycle in which cmd_tx_valid=0.
REQ-014 bridge_enable SHALL assert in the same cycle PASS is entered.
REQ-015 In PASS, each uart_rx_valid SHALL produce br_rx_valid with 1-cycle latency, and cmd_rx_valid SHALL stay 0.
REQ-016 In PASS, uart_tx_* SHALL connect to br_tx_*, and cmd_tx_ready SHALL be 0.
REQ-017 Under the valid/ready rule, a transfer occurs when valid && ready; the block SHALL never switch the TX mux while the selected source holds valid && !ready.
REQ-018 Idle counter: width is clog2(CLK_FREQ_HZ/1000*IDLE_TIMEOUT_MS)+1; it SHALL clear to 0 on entry to PASS, on uart_rx_valid, and on a br_tx transfer; otherwise it increments.
REQ-019 Exit from PASS to CMD SHALL occur when the idle counter reaches CLK_FREQ_HZ/1000*IDLE_TIMEOUT_MS-1, or when force_exit=1.
REQ-020 An exit SHALL be deferred while br_tx_valid && !uart_tx_ready.
REQ-021 On exit, bridge_enable SHALL deassert in the same cycle and the matcher SHALL clear.
REQ-022 When uart_rx_valid coincides with a timeout, the byte SHALL count as activity: the counter clears and there is no exit.
REQ-023 When force_exit coincides with uart_rx_valid, the exit wins and the byte is routed to the bridge (the last PASS byte).

Reset
REQ-024 On rst: state=CMD, matcher=0, idle counter=0, and bridge_enable, passthrough, cmd_rx_valid, and br_rx_valid SHALL all be 0; uart_tx_valid SHALL reflect cmd_tx_valid.
REQ-025 rst asserted in PASS SHALL return the block to CMD on the next edge regardless of a pending TX.

Structure
REQ-026 Package pc_uart_router_pkg SHALL hold the state enum (CMD, DRAIN, PASS) and the default ENTRY_SEQ constant.
REQ-027 Sub-module seq_matcher SHALL contain the 4-byte matcher (inputs: byte and strobe, clear; output: match pulse).

Verification
REQ-028 Bench parameters SHALL be IDLE_TIMEOUT_MS=1 (72,000 cycles).
REQ-029 Scenario 1: bytes 0x01, 0x02 in CMD -> cmd_rx_valid pulses carry 0x01, 0x02; br_rx_valid stays 0; passthrough=0.
REQ-030 Scenario 2: 0x42 0x4C 0x48 0x45 -> passthrough=1 and bridge_enable=1; the next byte 0x41 appears only on br_rx_data.
REQ-031 Scenario 3: 0x42 0x42 0x4C 0x48 0x45 (overlap) -> enters PASS; 0x42 0x4C 0x00 0x48 0x45 -> stays CMD.
REQ-032 Scenario 4: sequence sent while cmd_tx holds 0x99 with uart_tx_ready=0 for 100 cycles -> state held in DRAIN, 0x99 transmitted, then PASS.
REQ-033 Scenario 5: in PASS, no traffic -> exit at exactly 72,000 idle cycles; a byte at cycle 71,999 -> no exit.
REQ-034 Scenario 6: in PASS, br_tx 0x42 with uart_tx_ready=0 plus force_exit -> exit only after 0x42 is accepted; rst mid-PASS -> CMD with all outputs at reset values.
